// File: rtl/pwm_sched_pkg.sv
// Shared defaults and FSM encoding for the PWM period scheduler.
package pwm_sched_pkg;

  localparam int unsigned NCH_DEF = 3;  // channels served (1..4)
  localparam int unsigned CW_DEF  = 3;  // counter / duty width
  localparam int unsigned PSW_DEF = 4;  // prescaler width
  localparam int unsigned CHW     = 2;  // channel index width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_sched_prescaler.sv
// Tick divider: one tick every prescale+1 clocks while running, held at 0 when idle.
module pwm_sched_prescaler #(
  parameter int unsigned PSW = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           run_i,
  input  logic [PSW-1:0] prescale_i,
  output logic           tick_c_o
);

  logic [PSW-1:0] pcnt_q, pcnt_d;

  assign tick_c_o = run_i && (pcnt_q == '0);

  // Count down while running; reload with the current prescale on each tick.
  always_comb begin
    pcnt_d = pcnt_q;
    if (!run_i) begin
      pcnt_d = '0;
    end else if (pcnt_q == '0) begin
      pcnt_d = prescale_i;
    end else begin
      pcnt_d = pcnt_q - PSW'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/pwm_sched.sv
// Shared period counter and boundary-synchronised duty-cycle register bank.
module pwm_sched
  import pwm_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned PSW = PSW_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [PSW-1:0]    prescale_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_c_o,
  input  logic [CHW-1:0]    wr_ch_i,
  input  logic [CW-1:0]     wr_dc_i,
  output logic [CW-1:0]     trigger_o,
  output logic [NCH*CW-1:0] dc_bus_o,
  output logic              period_start_o,
  output logic              update_done_o,
  output logic              busy_o
);

  state_e              state_q, state_d;
  logic [CW-1:0]       trig_q, trig_d;
  logic [NCH*CW-1:0]   dc_q, dc_d;
  logic [NCH*CW-1:0]   pend_q, pend_d;
  logic [NCH-1:0]      pend_v_q, pend_v_d;
  logic                ps_q, ps_d;
  logic                ud_q, ud_d;
  logic                busy_q, busy_d;
  logic                tick, wrap, commit, accept, ch_free;

  pwm_sched_prescaler #(.PSW(PSW)) u_prescaler (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .run_i      (state_q != ST_IDLE),
    .prescale_i (prescale_i),
    .tick_c_o   (tick)
  );

  assign wrap = tick && (trig_q == '1);

  // Out-of-range channels are always ready; in-range ones block while pending.
  always_comb begin
    ch_free = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (wr_ch_i == CHW'(i)) ch_free = ~pend_v_q[i];
    end
  end

  assign wr_ready_c_o = ch_free;
  assign accept       = wr_valid_i && ch_free;

  // Run-state sequencing, counter advance and commit timing.
  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    commit  = 1'b0;
    ps_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        trig_d = '0;
        commit = |pend_v_q;
        if (en_i) begin
          state_d = ST_RUN;
          ps_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) trig_d = CW'(trig_q + CW'(1));
        if (wrap) begin
          commit = |pend_v_q;
          if (en_i) ps_d = 1'b1;
          else      state_d = ST_IDLE;
        end else if (!en_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tick) trig_d = CW'(trig_q + CW'(1));
        if (wrap) begin
          commit = |pend_v_q;
          if (en_i) begin
            state_d = ST_RUN;
            ps_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (en_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        trig_d  = '0;
      end
    endcase
    ud_d   = commit;
    busy_d = (state_d != ST_IDLE);
  end

  // Commit pending duties to the active bank, then capture any new write.
  always_comb begin
    dc_d     = dc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (commit && pend_v_q[i]) begin
        dc_d[i*CW +: CW] = pend_q[i*CW +: CW];
        pend_v_d[i]      = 1'b0;
      end
      if (accept && (wr_ch_i == CHW'(i))) begin
        pend_d[i*CW +: CW] = wr_dc_i;
        pend_v_d[i]        = 1'b1;
      end
    end
  end

  // State, counter, register bank and output pulse registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      trig_q   <= '0;
      dc_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= '0;
      ps_q     <= 1'b0;
      ud_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_d;
      dc_q     <= dc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ps_q     <= ps_d;
      ud_q     <= ud_d;
      busy_q   <= busy_d;
    end
  end

  assign trigger_o      = trig_q;
  assign dc_bus_o       = dc_q;
  assign period_start_o = ps_q;
  assign update_done_o  = ud_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_pwm_sched.sv
// Directed plus randomized bench for pwm_sched against a period-level reference model.
module tb_pwm_sched;

  localparam int NCH  = 3;
  localparam int CW   = 3;
  localparam int PSW  = 4;
  localparam int MAXV = (1 << CW) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic [PSW-1:0]  prescale = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [1:0]      wr_ch = '0;
  logic [CW-1:0]   wr_dc = '0;
  logic [CW-1:0]   trigger;
  logic [NCH*CW-1:0] dc_bus;
  logic            period_start, update_done, busy;

  int total = 0;
  int bad   = 0;

  // Reference model: run mode, prescale countdown, period count, duty bank.
  int m_mode, m_pc, m_trig, m_ps, m_ud, m_busy;
  int m_act[NCH];
  int m_pend[NCH];
  int m_pv[NCH];

  always #5 clk = ~clk;

  pwm_sched #(.NCH(NCH), .CW(CW), .PSW(PSW)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .en_i           (en),
    .prescale_i     (prescale),
    .wr_valid_i     (wr_valid),
    .wr_ready_c_o   (wr_ready),
    .wr_ch_i        (wr_ch),
    .wr_dc_i        (wr_dc),
    .trigger_o      (trigger),
    .dc_bus_o       (dc_bus),
    .period_start_o (period_start),
    .update_done_o  (update_done),
    .busy_o         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_ready(input int ch);
    return (ch >= NCH) || (m_pv[ch] == 0);
  endfunction

  function automatic logic [31:0] m_dcbus();
    logic [31:0] r = '0;
    for (int i = 0; i < NCH; i++) r = r | (32'(m_act[i]) << (i * CW));
    return r;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    int running, tick, wrap, any, commit, n_mode;
    if (reset) begin
      m_mode = M_IDLE; m_pc = 0; m_trig = 0; m_ps = 0; m_ud = 0; m_busy = 0;
      for (int i = 0; i < NCH; i++) begin m_act[i] = 0; m_pend[i] = 0; m_pv[i] = 0; end
      return;
    end
    running = (m_mode != M_IDLE);
    tick    = running && (m_pc == 0);
    wrap    = tick && (m_trig == MAXV);
    any     = 0;
    for (int i = 0; i < NCH; i++) if (m_pv[i] != 0) any = 1;
    commit  = (m_mode == M_IDLE || wrap) && any;
    if (m_mode == M_IDLE)     n_mode = en ? M_RUN : M_IDLE;
    else if (m_mode == M_RUN) n_mode = en ? M_RUN : (wrap ? M_IDLE : M_DRAIN);
    else                      n_mode = en ? M_RUN : (wrap ? M_IDLE : M_DRAIN);
    m_ps = ((wrap && n_mode != M_IDLE) || (m_mode == M_IDLE && en)) ? 1 : 0;
    if (wr_valid && m_ready(int'(wr_ch)) && int'(wr_ch) < NCH) begin
      if (commit) for (int i = 0; i < NCH; i++) if (m_pv[i] != 0) begin m_act[i] = m_pend[i]; m_pv[i] = 0; end
      m_pend[wr_ch] = int'(wr_dc);
      m_pv[wr_ch]   = 1;
    end else if (commit) begin
      for (int i = 0; i < NCH; i++) if (m_pv[i] != 0) begin m_act[i] = m_pend[i]; m_pv[i] = 0; end
    end
    m_pc   = running ? ((m_pc == 0) ? int'(prescale) : m_pc - 1) : 0;
    m_trig = running ? (tick ? (m_trig + 1) % (MAXV + 1) : m_trig) : 0;
    m_ud   = commit;
    m_mode = n_mode;
    m_busy = (n_mode != M_IDLE);
  endtask

  // One clock: check ready before the edge, outputs 1 time unit after it.
  task automatic cycle();
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(m_ready(int'(wr_ch))));
    model_step();
    @(posedge clk);
    #1;
    chk("trigger",      32'(trigger),      32'(m_trig));
    chk("dc_bus",       32'(dc_bus),       m_dcbus());
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("update_done",  32'(update_done),  32'(m_ud));
    chk("busy",         32'(busy),         32'(m_busy));
  endtask

  task automatic wait_trig(input int v);
    int n = 0;
    while (int'(trigger) != v && n < 100) begin cycle(); n++; end
    chk("wait_trigger", 32'(trigger), 32'(v));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin cycle(); n++; end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    cycle();
    cycle();
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_dc_bus",  32'(dc_bus),  32'd0);
    chk("rst_busy",    32'(busy),    32'd0);

    // Free run at full rate: 0,1..7,0 with period_start at each 0.
    reset = 1'b0; en = 1'b1; prescale = '0;
    cycle();
    chk("run_first_trig", 32'(trigger), 32'd0);
    chk("run_first_ps",   32'(period_start), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("run_seq", 32'(trigger), 32'(k % 8));
    end
    chk("run_wrap_ps", 32'(period_start), 32'd1);
    chk("run_busy",    32'(busy), 32'd1);

    // Divided rate, then back to full rate mid-run.
    prescale = 4'd2;
    for (int k = 0; k < 14; k++) cycle();
    prescale = 4'd0;
    for (int k = 0; k < 8; k++) cycle();

    // Idle write: commits straight away.
    en = 1'b0;
    wait_idle();
    wr_valid = 1'b1; wr_ch = 2'd1; wr_dc = 3'd5;
    cycle();
    wr_valid = 1'b0;
    chk("idle_not_yet", 32'(dc_bus), 32'd0);
    cycle();
    chk("idle_commit",  32'(dc_bus), 32'd40);
    chk("idle_ud",      32'(update_done), 32'd1);

    // Running write is held until the period boundary; second write back-pressured.
    en = 1'b1;
    wait_trig(2);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_dc = 3'd3;
    cycle();
    wr_dc = 3'd1;
    #1;
    chk("ch0_backpressure", 32'(wr_ready), 32'd0);
    chk("ch0_held", 32'(dc_bus[2:0]), 32'd0);
    begin
      int n = 0;
      while (dc_bus[2:0] != 3'd3 && n < 40) begin cycle(); n++; end
    end
    chk("ch0_commit", 32'(dc_bus[2:0]), 32'd3);
    chk("ch0_commit_trig", 32'(trigger), 32'd0);
    cycle();
    wr_valid = 1'b0;

    // Write on the wrap clock lands in the following period.
    wait_trig(7);
    wr_valid = 1'b1; wr_ch = 2'd2; wr_dc = 3'd6;
    cycle();
    wr_valid = 1'b0;
    chk("ch2_not_in_commit", 32'(dc_bus[8:6]), 32'd0);
    chk("ch0_second",        32'(dc_bus[2:0]), 32'd1);
    wr_valid = 1'b1; wr_ch = 2'd3; wr_dc = 3'd7;
    #1;
    chk("ch3_ready", 32'(wr_ready), 32'd1);
    cycle();
    wr_valid = 1'b0; wr_ch = 2'd0;
    wait_trig(7);
    cycle();
    chk("ch2_commit", 32'(dc_bus), 32'(9'b110_101_001));

    // Drain completes the period, then idle.
    wait_trig(4);
    en = 1'b0;
    cycle(); chk("drain5", 32'(trigger), 32'd5);
    cycle(); chk("drain6", 32'(trigger), 32'd6);
    cycle(); chk("drain7", 32'(trigger), 32'd7);
    chk("drain_busy", 32'(busy), 32'd1);
    cycle();
    chk("drain_idle_trig", 32'(trigger), 32'd0);
    chk("drain_idle_busy", 32'(busy), 32'd0);
    chk("drain_no_ps",     32'(period_start), 32'd0);

    // Reset mid-run.
    en = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_trigger", 32'(trigger), 32'd0);
    chk("midrst_dc",      32'(dc_bus),  32'd0);
    chk("midrst_busy",    32'(busy),    32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15) == 0) en = ~en;
      if ($urandom_range(31) == 0) prescale = PSW'($urandom_range(3));
      wr_valid = 1'($urandom_range(1));
      wr_ch    = 2'($urandom_range(3));
      wr_dc    = CW'($urandom);
      reset    = ($urandom_range(299) == 0);
      cycle();
    end
    reset = 1'b0; wr_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
